data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_pkg.sv | 52 +++++
 rtl/data_mem_resp_txq_fifo.sv | 71 +++++++
 rtl/data_mem_resp.sv | 165 ++++++++++++++++
 tb/tb_data_mem_resp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the address map, the decode mask widths, the UART status bit
// positions, the access request struct and the byte-merge helper used for
// byte-enabled register writes.
package data_mem_resp_pkg;

  localparam int XLEN       = 64;
  // Decode works on 64-bit words; the byte offset inside a word is ignored.
  localparam int WORD_OFS_W = 3;
  localparam int WADDR_W    = XLEN - WORD_OFS_W;

  localparam logic [XLEN-1:0] MTIMECMP_ADDR = 64'h0200_4000;
  localparam logic [XLEN-1:0] MTIME_ADDR    = 64'h0200_BFF8;
  localparam logic [XLEN-1:0] UART_ADDR     = 64'h1000_0000;

  localparam logic [WADDR_W-1:0] MTIMECMP_WADDR = MTIMECMP_ADDR[XLEN-1:WORD_OFS_W];
  localparam logic [WADDR_W-1:0] MTIME_WADDR    = MTIME_ADDR[XLEN-1:WORD_OFS_W];
  localparam logic [WADDR_W-1:0] UART_WADDR     = UART_ADDR[XLEN-1:WORD_OFS_W];

  // UART status word: byte 5 bit 5 = room in TX queue, byte 5 bit 6 = queue empty.
  localparam int UART_ST_NOTFULL_BIT = 8 * 5 + 5;
  localparam int UART_ST_EMPTY_BIT   = 8 * 5 + 6;

  typedef enum logic [2:0] {
    RGN_NONE     = 3'd0,
    RGN_RAM      = 3'd1,
    RGN_MTIMECMP = 3'd2,
    RGN_MTIME    = 3'd3,
    RGN_UART     = 3'd4
  } region_e;

  // One memory-stage access as seen by the responder.
  typedef struct packed {
    logic            en;
    logic [7:0]      we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_w,
                                                 input logic [XLEN-1:0] new_w,
                                                 input logic [7:0]      be);
    logic [XLEN-1:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_resp_txq_fifo.sv
// UART transmit queue: 8-bit wide, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the queue)
//   push_i, din_i   enqueue request and byte
//   pop_i           dequeue request (ignored while empty)
//   dout_o          head byte
//   full_o, empty_o occupancy flags
//   count_o         number of queued bytes
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the byte is dropped.
module txq_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot this push needs.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder for the memory stage: byte-enabled RAM, CLINT-style
// mtime/mtimecmp timer and a UART transmit queue behind one 64-bit port.
// Every access completes in one cycle; there is no stall path.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   data_addra      byte address (bits [2:0] ignored)
//   data_ena        access enable
//   data_wea        byte write enables (zero = read)
//   data_dina       write data
//   data_douta      read data, one cycle after the access edge; writes return
//                   the word as it was before the write
//   timer_irq       registered mtime >= mtimecmp
//   uart_tx_valid   TX queue not empty
//   uart_tx_data    TX queue head byte
//   uart_tx_ready   sink takes the head byte when high with uart_tx_valid
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int          RAM_DEPTH_LOG2 = 12,
  parameter logic [63:0] RAM_BASE       = 64'h8000_0000,
  parameter int          TXQ_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_addra,
  input  logic        data_ena,
  input  logic [7:0]  data_wea,
  input  logic [63:0] data_dina,
  output logic [63:0] data_douta,
  output logic        timer_irq,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready
);

  localparam int RAM_WORDS = 1 << RAM_DEPTH_LOG2;

  mem_req_t req;
  assign req.en    = data_ena;
  assign req.we    = data_wea;
  assign req.addr  = data_addra;
  assign req.wdata = data_dina;

  // Address decode on the word address.
  logic [WADDR_W-1:0]        waddr, ram_base_w, ram_ofs;
  logic [RAM_DEPTH_LOG2-1:0] ram_idx;
  logic                      unused_byte_ofs;
  logic                      is_write;
  region_e                   rgn;

  assign waddr           = req.addr[XLEN-1:WORD_OFS_W];
  assign ram_base_w      = RAM_BASE[XLEN-1:WORD_OFS_W];
  assign ram_ofs         = waddr - ram_base_w;
  assign ram_idx         = ram_ofs[RAM_DEPTH_LOG2-1:0];
  assign unused_byte_ofs = ^req.addr[WORD_OFS_W-1:0];
  assign is_write        = |req.we;

  always_comb begin
    rgn = RGN_NONE;
    // Below-base addresses wrap ram_ofs to a huge value, so both bounds are checked.
    if ((waddr >= ram_base_w) && ((ram_ofs >> RAM_DEPTH_LOG2) == '0)) rgn = RGN_RAM;
    else if (waddr == MTIMECMP_WADDR)                                    rgn = RGN_MTIMECMP;
    else if (waddr == MTIME_WADDR)                                       rgn = RGN_MTIME;
    else if (waddr == UART_WADDR)                                        rgn = RGN_UART;
  end

  // RAM: no reset, registered read-first port so it maps onto block RAM.
  logic [63:0] ram_mem [RAM_WORDS];
  logic [63:0] ram_rdata_q;

  always_ff @(posedge clk) begin
    if (req.en) begin
      ram_rdata_q <= ram_mem[ram_idx];
      if (rgn == RGN_RAM) begin
        for (int b = 0; b < 8; b++) begin
          if (req.we[b]) ram_mem[ram_idx][8*b +: 8] <= req.wdata[8*b +: 8];
        end
      end
    end
  end

  // UART transmit queue.
  logic       txq_push, txq_pop, txq_full, txq_empty;
  logic [7:0] txq_dout;
  logic [$clog2(TXQ_DEPTH):0] txq_count_unused;

  assign txq_pop  = uart_tx_valid && uart_tx_ready;
  assign txq_push = req.en && (rgn == RGN_UART) && req.we[0];

  txq_fifo #(
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (txq_push),
    .din_i   (req.wdata[7:0]),
    .pop_i   (txq_pop),
    .dout_o  (txq_dout),
    .full_o  (txq_full),
    .empty_o (txq_empty),
    .count_o (txq_count_unused)
  );

  assign uart_tx_valid = !txq_empty;
  assign uart_tx_data  = txq_dout;

  // Timer next state: a write freezes the counter for that cycle.
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        timer_irq_q, timer_irq_d;
  logic        mtime_wr, mtimecmp_wr;

  assign mtime_wr    = req.en && is_write && (rgn == RGN_MTIME);
  assign mtimecmp_wr = req.en && is_write && (rgn == RGN_MTIMECMP);

  always_comb begin
    mtime_d    = mtime_wr ? byte_merge(mtime_q, req.wdata, req.we) : mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_wr ? byte_merge(mtimecmp_q, req.wdata, req.we) : mtimecmp_q;
    // Compare the values being loaded so the irq tracks the new state one cycle later.
    timer_irq_d = (mtime_d >= mtimecmp_d);
  end

  // Peripheral read data, sampled from the pre-update register values.
  logic [63:0] uart_status, periph_rd;

  always_comb begin
    uart_status = '0;
    uart_status[UART_ST_NOTFULL_BIT] = !txq_full;
    uart_status[UART_ST_EMPTY_BIT]   = txq_empty;
    case (rgn)
      RGN_MTIME:    periph_rd = mtime_q;
      RGN_MTIMECMP: periph_rd = mtimecmp_q;
      RGN_UART:     periph_rd = uart_status;
      default:      periph_rd = '0;
    endcase
  end

  // Read-response source select; held while data_ena is low.
  region_e     rsel_q, rsel_d;
  logic [63:0] prd_q, prd_d;

  assign rsel_d = req.en ? rgn : rsel_q;
  assign prd_d  = req.en ? periph_rd : prd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      timer_irq_q <= 1'b0;
      rsel_q      <= RGN_NONE;
      prd_q       <= '0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= timer_irq_d;
      rsel_q      <= rsel_d;
      prd_q       <= prd_d;
    end
  end

  // Reset forces rsel_q to RGN_NONE, so the unreset RAM register never shows.
  assign data_douta = (rsel_q == RGN_RAM) ? ram_rdata_q : prd_q;
  assign timer_irq  = timer_irq_q;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  localparam int          DL2  = 6;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] A_CMP  = 64'h0200_4000;
  localparam logic [63:0] A_MT   = 64'h0200_BFF8;
  localparam logic [63:0] A_UART = 64'h1000_0000;
  localparam logic [63:0] ST_EMPTY = 64'h0000_6000_0000_0000;
  localparam logic [63:0] ST_FULL  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] W_RST    = 64'h5A5A_1234_8765_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_addra = '0;
  logic        data_ena = 1'b0;
  logic [7:0]  data_wea = '0;
  logic [63:0] data_dina = '0;
  logic [63:0] data_douta;
  logic        timer_irq;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  uart_q[$];
  logic        chk_v = 1'b0;
  logic        chk_flag = 1'b0;

  data_mem_resp #(
    .RAM_DEPTH_LOG2 (DL2),
    .RAM_BASE       (BASE),
    .TXQ_DEPTH      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_addra    (data_addra),
    .data_ena      (data_ena),
    .data_wea      (data_wea),
    .data_dina     (data_dina),
    .data_douta    (data_douta),
    .timer_irq     (timer_irq),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: read responses and UART transfers.
  always @(posedge clk) chk_flag <= chk_v;

  always @(negedge clk) begin
    if (chk_flag) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL douta_sb: unexpected response %h, no expectation queued", data_douta);
      end else begin
        check64("douta", data_douta, exp_q.pop_front());
      end
    end
    if (!rst && uart_tx_valid && uart_tx_ready) begin
      if (uart_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL uart_sb: unexpected byte %h, none queued", uart_tx_data);
      end else begin
        check64("uart_tx_data", {56'h0, uart_tx_data}, {56'h0, uart_q.pop_front()});
      end
    end
  end

  task automatic acc(input logic [63:0] a, input logic [7:0] we, input logic [63:0] d,
                     input bit chk, input logic [63:0] e);
    data_addra = a;
    data_wea   = we;
    data_dina  = d;
    data_ena   = 1'b1;
    chk_v      = chk;
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    #1;
    data_ena = 1'b0;
    data_wea = '0;
    chk_v    = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, input logic [63:0] e);
    acc(a, 8'h00, 64'h0, 1'b1, e);
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] we, input logic [63:0] d);
    acc(a, we, d, 1'b0, 64'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check64("rst_douta", data_douta, 64'h0);
    check64("rst_irq", {63'h0, timer_irq}, 64'h0);
    check64("rst_valid", {63'h0, uart_tx_valid}, 64'h0);
    rst = 1'b0;

    // Timer.
    wr(A_CMP, 8'hFF, 64'd10);
    wr(A_MT, 8'hFF, 64'd0);
    idle(9);
    check64("irq_before_10", {63'h0, timer_irq}, 64'h0);
    idle(1);
    check64("irq_at_10", {63'h0, timer_irq}, 64'h1);
    rd(A_MT, 64'd10);
    wr(A_MT, 8'hFF, 64'd0);
    check64("irq_after_mtime_wr", {63'h0, timer_irq}, 64'h0);
    rd(A_MT, 64'd0);
    rd(A_CMP, 64'd10);
    wr(A_MT, 8'h02, 64'h0000_0000_0000_AB00);
    rd(A_MT, 64'h0000_0000_0000_AB02);

    // RAM byte enables and read-first.
    wr(BASE, 8'hFF, 64'h1122_3344_5566_7788);
    acc(BASE, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b1, 64'h1122_3344_5566_7788);
    rd(BASE, 64'h1122_3344_BBBB_BBBB);
    rd(BASE + 64'd5, 64'h1122_3344_BBBB_BBBB);
    wr(BASE + 64'd8, 8'hFF, 64'hCAFE_0000_0000_0001);
    rd(BASE + 64'd8, 64'hCAFE_0000_0000_0001);
    acc(BASE + 64'd8, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, 64'hCAFE_0000_0000_0001);
    rd(BASE + 64'd8, 64'h0123_4567_89AB_CDEF);
    // ena low: output holds even though the address points elsewhere.
    data_addra = BASE;
    chk_v = 1'b1;
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    #1;
    chk_v = 1'b0;

    // RAM boundaries and unmapped space.
    wr(BASE + 64'h1F8, 8'hFF, 64'hDEAD_BEEF_0000_1234);
    rd(BASE + 64'h1F8, 64'hDEAD_BEEF_0000_1234);
    rd(BASE + 64'h200, 64'h0);
    wr(BASE + 64'h200, 8'hFF, 64'h5);
    rd(BASE, 64'h1122_3344_BBBB_BBBB);
    rd(BASE - 64'd8, 64'h0);
    wr(64'h3000_0000, 8'hFF, 64'h77);
    rd(64'h3000_0000, 64'h0);

    // UART queue fill and overflow drop.
    rd(A_UART, ST_EMPTY);
    for (int i = 0; i < 9; i++) begin
      wr(A_UART, 8'h01, {56'h0, 8'h41 + 8'(i)});
      if (i < 8) uart_q.push_back(8'h41 + 8'(i));
    end
    rd(A_UART, ST_FULL);
    // Full queue: push with a simultaneous pop is accepted.
    uart_tx_ready = 1'b1;
    uart_q.push_back(8'h4A);
    wr(A_UART, 8'h01, 64'h4A);
    rd(A_UART, ST_FULL);
    begin
      int n;
      n = 0;
      while (uart_tx_valid && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      checks++;
      if (uart_tx_valid) begin
        errors++;
        $display("FAIL drain_timeout: valid still %0d after %0d cycles, required 0", uart_tx_valid, n);
      end
    end
    rd(A_UART, ST_EMPTY);
    check64("uart_q_drained", 64'(uart_q.size()), 64'h0);
    // Write without byte 0 enabled pushes nothing.
    wr(A_UART, 8'h02, 64'h4400);
    check64("no_push_wea0", {63'h0, uart_tx_valid}, 64'h0);

    // Asynchronous reset mid-operation.
    uart_tx_ready = 1'b0;
    wr(BASE + 64'd16, 8'hFF, W_RST);
    wr(A_UART, 8'h01, 64'h61);
    wr(A_UART, 8'h01, 64'h62);
    wr(A_UART, 8'h01, 64'h63);
    rd(BASE + 64'd16, W_RST);
    @(negedge clk);
    #1;
    check64("pre_rst_valid", {63'h0, uart_tx_valid}, 64'h1);
    check64("pre_rst_irq", {63'h0, timer_irq}, 64'h1);
    rst = 1'b1;
    #1;
    check64("async_rst_valid", {63'h0, uart_tx_valid}, 64'h0);
    check64("async_rst_douta", data_douta, 64'h0);
    check64("async_rst_irq", {63'h0, timer_irq}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    uart_tx_ready = 1'b1;
    idle(3);
    check64("post_rst_valid", {63'h0, uart_tx_valid}, 64'h0);
    rd(BASE + 64'd16, W_RST);
    rd(A_CMP, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(A_UART, ST_EMPTY);
    idle(2);

    check64("sb_douta_empty", 64'(exp_q.size()), 64'h0);
    check64("sb_uart_empty", 64'(uart_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
